// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - register-file write port producer for ALU results and in-order load responses
//
// Purpose: registers one register-file write per cycle from either an ALU
// result or a load response (load wins), tracks in-flight loads in a small
// metadata FIFO plus a per-register busy scoreboard, and extracts/extends
// load bytes and halfwords.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_result
//                                   single-cycle ALU result handshake
//   load_issue_valid/load_issue_ready/load_rd/load_funct3/load_addr_lo
//                                   load issue handshake and metadata
//   mem_rdata_valid/mem_rdata       in-order memory response (never stalled)
//   rs1_check/rs2_check/hazard      decode hazard query against busy bits
//   reg_write_control/select/data   registered register-file write port
//   protocol_err                    sticky error (orphan response, bad funct3)

module writeback_unit #(
  parameter int LOAD_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  input  logic        load_issue_valid,
  output logic        load_issue_ready,
  input  logic [4:0]  load_rd,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_addr_lo,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  input  logic [4:0]  rs1_check,
  input  logic [4:0]  rs2_check,
  output logic        hazard,
  output logic        reg_write_control,
  output logic [4:0]  reg_write_select,
  output logic [31:0] reg_write_data,
  output logic        protocol_err
);

  localparam int PW = (LOAD_DEPTH > 1) ? $clog2(LOAD_DEPTH) : 1;
  localparam int CW = $clog2(LOAD_DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(LOAD_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LOAD_DEPTH);

  // FIFO entry layout: {rd[9:5], funct3[4:2], addr_lo[1:0]}
  logic [LOAD_DEPTH-1:0][9:0] fifo_q, fifo_d;
  logic [PW-1:0]              head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]              count_q, count_d;
  logic [31:0]                busy_q, busy_d;
  logic                       wr_en_q, wr_en_d;
  logic [4:0]                 wr_sel_q, wr_sel_d;
  logic [31:0]                wr_data_q, wr_data_d;
  logic                       err_q, err_d;

  logic        fifo_empty, fifo_full;
  logic [9:0]  head_entry;
  logic [4:0]  h_rd;
  logic [2:0]  h_f3;
  logic [1:0]  h_lo;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        ld_bad;
  logic        push, pop, alu_fire;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign head_entry = fifo_q[head_q];
  assign h_rd       = head_entry[9:5];
  assign h_f3       = head_entry[4:2];
  assign h_lo       = head_entry[1:0];

  // Readiness uses only pre-edge state: a response freeing a slot or a
  // register this cycle does not open the door until the next cycle.
  assign alu_ready        = !mem_rdata_valid && !(alu_rd != 5'd0 && busy_q[alu_rd]);
  assign load_issue_ready = !fifo_full && !(load_rd != 5'd0 && busy_q[load_rd]);
  assign hazard           = busy_q[rs1_check] | busy_q[rs2_check];

  assign push     = load_issue_valid && load_issue_ready;
  assign pop      = mem_rdata_valid && !fifo_empty;
  assign alu_fire = alu_valid && alu_ready;

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (h_lo)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = h_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_bad  = 1'b0;
    case (h_f3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = mem_rdata;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: begin
        ld_data = '0;
        ld_bad  = 1'b1;
      end
    endcase
  end

  always_comb begin
    fifo_d    = fifo_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    busy_d    = busy_q;
    wr_en_d   = 1'b0;
    wr_sel_d  = '0;
    wr_data_d = '0;
    err_d     = err_q;

    if (pop) begin
      wr_en_d   = (h_rd != 5'd0);
      wr_sel_d  = h_rd;
      wr_data_d = ld_data;
      busy_d[h_rd] = 1'b0;
      head_d = (head_q == LAST_IDX) ? '0 : head_q + PW'(1);
      if (ld_bad) err_d = 1'b1;
    end else if (alu_fire) begin
      wr_en_d   = (alu_rd != 5'd0);
      wr_sel_d  = alu_rd;
      wr_data_d = alu_result;
    end

    if (mem_rdata_valid && fifo_empty) err_d = 1'b1;

    // push can never target the rd being popped: that rd is still busy
    if (push) begin
      fifo_d[tail_q] = {load_rd, load_funct3, load_addr_lo};
      tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + PW'(1);
      if (load_rd != 5'd0) busy_d[load_rd] = 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    busy_d[0] = 1'b0;
    // Non-busy writes of x0 never reach the register file; keep the bus clean.
    if (!wr_en_d) begin
      wr_sel_d  = '0;
      wr_data_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q    <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      fifo_q    <= fifo_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_sel_q  <= wr_sel_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign reg_write_control = wr_en_q;
  assign reg_write_select  = wr_sel_q;
  assign reg_write_data    = wr_data_q;
  assign protocol_err      = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - scoreboard bench for writeback_unit with a queue-based reference model

module tb_writeback_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        load_issue_valid;
  logic        load_issue_ready;
  logic [4:0]  load_rd;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_lo;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic [4:0]  rs1_check;
  logic [4:0]  rs2_check;
  logic        hazard;
  logic        reg_write_control;
  logic [4:0]  reg_write_select;
  logic [31:0] reg_write_data;
  logic        protocol_err;

  writeback_unit #(.LOAD_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
    .load_issue_valid(load_issue_valid), .load_issue_ready(load_issue_ready),
    .load_rd(load_rd), .load_funct3(load_funct3), .load_addr_lo(load_addr_lo),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
    .rs1_check(rs1_check), .rs2_check(rs2_check), .hazard(hazard),
    .reg_write_control(reg_write_control), .reg_write_select(reg_write_select),
    .reg_write_data(reg_write_data), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  typedef struct { int cyc; logic [4:0] sel; logic [31:0] data; } exp_t;
  typedef struct { logic [4:0] rd; logic [2:0] f3; logic [1:0] lo; } ld_t;

  exp_t exq[$];
  ld_t  pend[$];
  bit   merr = 1'b0;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: a register is busy exactly when some outstanding load targets it.
  function automatic bit mbusy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (pend[i]) if (pend[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit mbad(input logic [2:0] f3);
    return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
  endfunction

  function automatic logic [31:0] mextract(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * int'(lo))) & 32'hFF;
    h = lo[1] ? (w >> 16) : (w & 32'hFFFF);
    case (f3)
      3'd0: return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd2: return w;
      3'd4: return b;
      3'd5: return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ares,
                      input logic lv, input logic [4:0] lrd, input logic [2:0] lf3, input logic [1:0] llo,
                      input logic mv, input logic [31:0] md, input logic [4:0] r1, input logic [4:0] r2);
    bit ear, eir, ehz;
    ld_t h, n;
    exp_t e;
    @(posedge clk);
    #1;
    alu_valid = av; alu_rd = ard; alu_result = ares;
    load_issue_valid = lv; load_rd = lrd; load_funct3 = lf3; load_addr_lo = llo;
    mem_rdata_valid = mv; mem_rdata = md; rs1_check = r1; rs2_check = r2;
    #1;
    chk("protocol_err", protocol_err, merr);
    ear = !mv && !mbusy(ard);
    eir = (pend.size() < DEPTH) && !mbusy(lrd);
    ehz = mbusy(r1) || mbusy(r2);
    chk("alu_ready", alu_ready, ear);
    chk("load_issue_ready", load_issue_ready, eir);
    chk("hazard", hazard, ehz);
    if (mv && pend.size() == 0) begin
      merr = 1'b1;
    end else if (mv) begin
      h = pend.pop_front();
      if (mbad(h.f3)) merr = 1'b1;
      if (h.rd != 5'd0) begin
        e.cyc = cyc + 1; e.sel = h.rd; e.data = mextract(h.f3, h.lo, md);
        exq.push_back(e);
      end
    end else if (av && ear && ard != 5'd0) begin
      e.cyc = cyc + 1; e.sel = ard; e.data = ares;
      exq.push_back(e);
    end
    if (lv && eir) begin
      n.rd = lrd; n.f3 = lf3; n.lo = llo;
      pend.push_back(n);
    end
  endtask

  task automatic idle(input logic [4:0] r1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  task automatic do_reset(input logic [4:0] r1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    alu_valid = 0; load_issue_valid = 0; mem_rdata_valid = 0; rs1_check = r1; rs2_check = 0;
    #1;
    chk("rst_control", reg_write_control, 1'b0);
    chk("rst_select", reg_write_select, 5'd0);
    chk("rst_data", reg_write_data, 32'd0);
    chk("rst_err", protocol_err, 1'b0);
    chk("rst_hazard", hazard, 1'b0);
    exq.delete();
    pend.delete();
    merr = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every registered write must match the next scoreboard entry, in its cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_write_control) begin
        if (exq.size() == 0) begin
          chk("unexpected_write", reg_write_select, 5'd0);
        end else begin
          mon_e = exq.pop_front();
          chk("write_cycle", cyc, mon_e.cyc);
          chk("write_select", reg_write_select, mon_e.sel);
          chk("write_data", reg_write_data, mon_e.data);
        end
      end else if (exq.size() > 0 && exq[0].cyc <= cyc) begin
        mon_e = exq.pop_front();
        chk("missed_write", 32'd0, 32'd1);
      end
    end
  end

  logic [2:0] vf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    reset = 1'b1;
    alu_valid = 0; alu_rd = 0; alu_result = 0;
    load_issue_valid = 0; load_rd = 0; load_funct3 = 0; load_addr_lo = 0;
    mem_rdata_valid = 0; mem_rdata = 0; rs1_check = 0; rs2_check = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("reset_control", reg_write_control, 1'b0);
    chk("reset_select", reg_write_select, 5'd0);
    chk("reset_data", reg_write_data, 32'd0);
    chk("reset_err", protocol_err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ALU write and single-cycle pulse
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    chk("alu_ctl", reg_write_control, 1'b1);
    chk("alu_sel", reg_write_select, 5'd5);
    chk("alu_data", reg_write_data, 32'hDEADBEEF);
    idle(0);
    chk("alu_pulse", reg_write_control, 1'b0);

    // LB with sign extension and hazard lifetime
    step(0, 0, 0, 1, 7, 3'd0, 2'd3, 0, 0, 7, 0);
    idle(7);
    chk("lb_hazard", hazard, 1'b1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF1234, 7, 0);
    idle(7);
    chk("lb_sel", reg_write_select, 5'd7);
    chk("lb_data", reg_write_data, 32'hFFFFFF80);
    chk("lb_hazard_clear", hazard, 1'b0);

    // Back-to-back loads fill the FIFO; third issue blocked
    step(0, 0, 0, 1, 3, 3'd5, 2'd2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 4, 3'd2, 2'd0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 8, 3'd2, 2'd0, 0, 0, 0, 0);
    chk("full_blocks_issue", load_issue_ready, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hABCD0001, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h11223344, 0, 0);
    chk("lhu_data", reg_write_data, 32'h0000ABCD);
    idle(0);
    chk("lw_data", reg_write_data, 32'h11223344);

    // Load response beats a simultaneous ALU result
    step(0, 0, 0, 1, 10, 3'd2, 2'd0, 0, 0, 0, 0);
    step(1, 9, 32'h99, 0, 0, 0, 0, 1, 32'h0A0A0A0A, 0, 0);
    chk("alu_stalled", alu_ready, 1'b0);
    step(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("load_first", reg_write_select, 5'd10);
    idle(0);
    chk("alu_second", reg_write_select, 5'd9);

    // WAW on rd6 blocks ALU until load retires; load to x0 is silent
    step(0, 0, 0, 1, 6, 3'd2, 2'd0, 0, 0, 0, 0);
    step(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_waw_block", alu_ready, 1'b0);
    step(1, 6, 32'h66, 0, 0, 0, 0, 1, 32'h600D, 0, 0);
    step(1, 6, 32'h67, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_waw_release", alu_ready, 1'b1);
    step(0, 0, 0, 1, 0, 3'd2, 2'd0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0);
    idle(0);
    chk("x0_no_write", reg_write_control, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), vf3[$urandom_range(0, 4)],
           2'($urandom_range(0, 3)),
           (pend.size() > 0) && ($urandom_range(0, 2) == 0), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    while (pend.size() > 0) step(0, 0, 0, 0, 0, 0, 0, 1, $urandom, 0, 0);
    idle(0);
    idle(0);

    // Unsupported funct3: data 0, write performed, sticky error
    step(0, 0, 0, 1, 13, 3'd3, 2'd0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 0);
    idle(0);
    chk("bad_f3_sel", reg_write_select, 5'd13);
    chk("bad_f3_data", reg_write_data, 32'd0);
    chk("bad_f3_err", protocol_err, 1'b1);

    // Reset in the middle of loads and a pending write
    step(0, 0, 0, 1, 12, 3'd2, 2'd0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 14, 3'd0, 2'd1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555AAAA, 14, 0);
    do_reset(14);

    // Orphan response after reset sets a sticky error
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0);
    idle(0);
    chk("orphan_err", protocol_err, 1'b1);
    chk("orphan_no_write", reg_write_control, 1'b0);
    for (int i = 0; i < 4; i++) idle(0);
    chk("err_sticky", protocol_err, 1'b1);

    chk("scoreboard_drained", exq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Producer side of the register-file write port: generates reg_write_control / reg_write_select / reg_write_data from two sources.
  - Single-cycle ALU results.
  - Multi-cycle load responses from data memory.
- Tracks in-flight loads in a metadata FIFO and a per-register busy scoreboard, so decode can stall on RAW/WAW hazards.
- Performs load byte/halfword extraction and sign/zero extension.

Parameters:
- LOAD_DEPTH, 2, max outstanding loads (metadata FIFO depth, ≥1).

Ports:
- clk  in  1  system clock, rising-edge state.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_result  in  32  ALU result.
- load_issue_valid  in  1  load being issued to memory.
- load_issue_ready  out  1  load issue accepted.
- load_rd  in  5  load destination.
- load_funct3  in  3  load type (RV32I encoding).
- load_addr_lo  in  2  address bits [1:0].
- mem_rdata_valid  in  1  memory read response (in order, cannot be stalled).
- mem_rdata  in  32  aligned memory word.
- rs1_check  in  5  source register query.
- rs2_check  in  5  source register query.
- hazard  out  1  rs1_check or rs2_check busy.
- reg_write_control  out  1  write enable toward register file.
- reg_write_select  out  5  write address.
- reg_write_data  out  32  write data.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (async): reg_write_control=0, reg_write_select=0, reg_write_data=0, protocol_err=0, FIFO empty, all busy bits 0.
  - Reset mid-operation discards pending loads.
  - A later orphan response sets protocol_err.
- Write outputs are registered.
  - Source accepted in cycle N → reg_write_* valid for exactly cycle N+1.
  - reg_write_control=0 in any cycle with no accepted source.
  - At most one write per cycle.
- Priority: a load response always wins.
  - alu_ready = !mem_rdata_valid && !(alu_rd!=0 && busy[alu_rd]).
  - ALU transfer occurs when alu_valid && alu_ready.
- Load issue: load_issue_ready = !fifo_full && !(load_rd!=0 && busy[load_rd]).
  - On transfer, push {rd, funct3, addr_lo} and set busy[rd] (rd≠0).
- Load response: pop FIFO head, extract and extend data, clear busy[head.rd] at the same edge that registers the write.
  - FIFO empty when a response arrives → response ignored, protocol_err=1.
- Extraction:
  - byte = mem_rdata[8*addr_lo +: 8].
  - half = addr_lo[1] ? [31:16] : [15:0].
  - 000 LB sign-extend byte.
  - 001 LH sign-extend half.
  - 010 LW full word.
  - 100 LBU zero-extend byte.
  - 101 LHU zero-extend half.
  - Other funct3: data 0, write still performed, protocol_err=1.
- Destination x0 (ALU or load): transfer consumed, never sets busy, produces reg_write_control=0.
- Scoreboard:
  - busy[0] is always 0.
  - hazard is combinational from the registered busy bits.
  - A register cleared at edge E reads non-busy in the cycle after E. The register file commits on the negedge of that cycle, so a combinational read sampled at the next posedge sees the new value.
- Simultaneous events:
  - Response and issue to the same rd in the same cycle: issue blocked (busy still set), accepted next cycle.
  - Response and issue to different rd: both proceed; FIFO push and pop in the same cycle keep the count unchanged, and a full FIFO may accept an issue only if its ready was already high. ready uses the pre-edge count, so full blocks issue.
  - Response plus alu_valid: ALU stalled one cycle.
- protocol_err clears only on reset.

Test Plan:
- Reset then ALU write alu_rd=5, result 0xDEADBEEF → next cycle reg_write_control=1, select=5, data 0xDEADBEEF; following cycle control=0.
- Issue LB rd=7, addr_lo=3; response mem_rdata=0x80FF_1234:
  - hazard=1 while rs1_check=7 pending.
  - Response gives write rd=7, data 0xFFFFFF80.
  - hazard=0 the cycle after.
- Issue LHU rd=3, addr_lo=2 and LW rd=4 back-to-back; third issue blocked (ready=0, depth 2):
  - Response 0xABCD0001 → rd3=0x0000ABCD.
  - Response 0x11223344 → rd4=0x11223344, in order.
- mem_rdata_valid with alu_valid (alu_rd=9) the same cycle → load written first, alu_ready=0, ALU written the following cycle.
- ALU to rd=6 while load to rd=6 pending → alu_ready=0 until the response is written; load to rd=0 → no write, no busy.
- Orphan mem_rdata_valid after reset, and funct3=011 load → protocol_err=1 and held; reset asserted mid-load → all outputs 0 immediately, busy cleared.
